guess_input: RTL
================

# guess_input

Upstream input-conditioning stage for the four-digit guessing game. It debounces the raw submit key, captures the 16-bit switch code on a clean press, and checks that the code holds four distinct digits. A valid code is presented to the game FSM through a valid/ready handshake, while an invalid code raises a one-cycle reject pulse with a reason. The block also counts accepted submissions for display.

## Interface
Parameters:
- DEB_CYCLES, 4 — number of consecutive identical raw samples required to change the debounced key level (≥2).
- CNT_W, 4 — width of the accepted-submission counter.

Ports:
- clk18  in  1  — system clock; all logic on posedge.
- rst  in  1  — reset, asynchronous, active-low.
- key_n  in  1  — raw submit key, low = pressed (KEY[3]).
- sw  in  16  — digit switches; [15:12] d3, [11:8] d2, [7:4] d1, [3:0] d0.
- clr  in  1  — synchronous abort/clear from game FSM, one cycle.
- code  out  16  — captured code; stable while code_valid=1.
- code_valid  out  1  — captured code is legal and awaiting consumption.
- code_ready  in  1  — consumer accepts code this cycle.
- reject  out  1  — one-cycle pulse: captured code illegal.
- reject_why  out  2  — 2'b01 duplicate digit, 2'b10 digit out of range; held until next capture.
- key_db  out  1  — debounced key level, 1 = pressed.
- attempts  out  CNT_W  — accepted handshakes, saturating at all-ones.

## Operation
- Debounce: sample key_n every edge into a DEB_CYCLES-bit shift register. key_db goes to 1 when all samples are 0, goes to 0 when all samples are 1, and holds otherwise.
- press_ev: registered; high for exactly one cycle after key_db rises.
- FSM states: IDLE, CHECK, HOLD, RELEASE.
- IDLE:
  - On press_ev, latch sw into code and go to CHECK.
  - Ignore sw changes otherwise.
- CHECK (one cycle): evaluate the latched code.
  - Range check (see Configuration): any nibble > 9 → illegal, reason 2'b10.
  - Else any two nibbles equal (all 6 pairs checked) → illegal, reason 2'b01.
  - Range has priority over duplicate.
  - Legal → go to HOLD.
  - Illegal → pulse reject, load reject_why, go to RELEASE.
- HOLD:
  - code_valid=1.
  - On code_ready=1, complete the handshake: attempts+1 (saturating); go to RELEASE if key_db=1, else IDLE.
  - Presses and sw changes during HOLD are ignored.
- RELEASE: wait for key_db=0, then go to IDLE. This enforces one submission per physical press.
- clr:
  - Highest priority in every state.
  - Clears code_valid and attempts to 0 and cancels any pending handshake; no reject pulse.
  - Next state is RELEASE if key_db=1, else IDLE.
- code_valid depends only on state; it never combinationally depends on code_ready.

## Timing
- Reset values:
  - code=16'h0000, code_valid=0, reject=0, reject_why=2'b00, key_db=0, attempts=0.
  - Shift register all ones; state IDLE.
- Press latency: key_n low from edge k (sampled at k, stable thereafter):
  - key_db=1 after edge k+DEB_CYCLES-1.
  - press_ev=1 after edge k+DEB_CYCLES.
  - code captured at edge k+DEB_CYCLES+1 (CHECK).
  - code_valid=1 or reject=1 after edge k+DEB_CYCLES+2.
- Handshake: transfer occurs on the edge where code_valid and code_ready are both 1. code_valid drops the following cycle; no back-to-back transfers.
- A bounce shorter than DEB_CYCLES samples produces no key_db change.
- clr on the same edge as a handshake: clr wins, attempts=0.

## Configuration
- GUESS_INPUT_DEC_CHECK_EN:
  - Defined: the range check is active; nibbles A–F are rejected with reason 2'b10.
  - Undefined: all hex digits are legal, only distinctness is checked, and reject_why is never 2'b10.

## Structure
- Shared package guess_pkg:
  - FSM state enum (IDLE, CHECK, HOLD, RELEASE).
  - Reject reason constants: REJ_NONE=2'b00, REJ_DUP=2'b01, REJ_RANGE=2'b10.
  - Digit nibble slice constants.
- Sub-module key_debounce(clk18, rst, key_n, key_db, press_ev), parameterised by DEB_CYCLES. Legality check and FSM stay in guess_input.

## Test plan
- Legal code: sw=16'h1234, key_n held low 10 cycles, code_ready=1 → code_valid high one cycle with code=16'h1234; attempts=1; reject never pulses.
- Duplicate digit: sw=16'h1231, press → reject pulses one cycle, reject_why=2'b01, code_valid stays 0, attempts unchanged.
- Range (macro defined): sw=16'h12A4, press → reject, reject_why=2'b10. Macro undefined: same stimulus → code_valid with code=16'h12A4.
- Bounce: key_n low 3 cycles, high 1, low 2, then high (DEB_CYCLES=4) → key_db stays 0, no capture. Then a long press gives exactly one code_valid.
- Backpressure and hold: sw=16'h5678, press, code_ready=0 for 20 cycles with sw changed to 16'h9012 and key re-pressed → code stays 16'h5678 and code_valid stays high. Then code_ready=1 → one transfer; a second capture occurs only after release and a new press.
- Clear/reset mid-operation: in HOLD assert clr → code_valid=0 next cycle, attempts=0. Async rst in CHECK → all outputs take reset values immediately. Sixteen accepted submissions with CNT_W=4 → attempts saturates at 4'hF.

Source files
------------

// File: rtl/guess_pkg.sv
// guess_pkg: shared FSM states, reject reasons and digit slicing for the guess input stage.
package guess_pkg;
   typedef enum logic [1:0] {IDLE, CHECK, HOLD, RELEASE} state_t;
   localparam logic [1:0] REJ_NONE  = 2'b00;
   localparam logic [1:0] REJ_DUP   = 2'b01;
   localparam logic [1:0] REJ_RANGE = 2'b10;
   localparam int NIB_W = 4;
   localparam int N_DIG = 4;
   localparam logic [NIB_W-1:0] MAX_DEC = 4'd9;
   function automatic logic [NIB_W-1:0] digit(input logic [N_DIG*NIB_W-1:0] c, input int i);
      return c[i*NIB_W +: NIB_W];
   endfunction
endpackage

// File: rtl/guess_input_key_debounce.sv
// key_debounce: sample-window debouncer for the active-low submit key with a one-cycle press event.
module key_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk18,
   input  logic rst,
   input  logic key_n,
   output logic key_db,
   output logic press_ev
);
   logic [DEB_CYCLES-2:0] hist;
   logic [DEB_CYCLES-1:0] win;
   logic                  db_d;
   // The window includes the sample being taken now, so key_db flips on the edge the window fills.
   assign win = {hist, key_n};
   always_ff @(posedge clk18 or negedge rst)
      if (!rst) begin
         hist     <= '1;
         key_db   <= 1'b0;
         db_d     <= 1'b0;
         press_ev <= 1'b0;
      end else begin
         hist     <= win[DEB_CYCLES-2:0];
         key_db   <= (win == '0) ? 1'b1 : (&win) ? 1'b0 : key_db;
         db_d     <= key_db;
         press_ev <= key_db & ~db_d;
      end
endmodule

// File: rtl/guess_input.sv
// guess_input: debounce, capture and validate a four-digit code, hand it off via valid/ready.
// Define GUESS_INPUT_DEC_CHECK_EN to also reject hex digits A-F.
module guess_input
   import guess_pkg::*;
#(
   parameter int DEB_CYCLES = 4,
   parameter int CNT_W      = 4
) (
   input  logic             clk18,
   input  logic             rst,
   input  logic             key_n,
   input  logic [15:0]      sw,
   input  logic             clr,
   output logic [15:0]      code,
   output logic             code_valid,
   input  logic             code_ready,
   output logic             reject,
   output logic [1:0]       reject_why,
   output logic             key_db,
   output logic [CNT_W-1:0] attempts
);
   state_t     state, nxt;
   logic       press_ev, cap, xfer, rej, dup, range_err;
   logic [1:0] why;
   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk18    (clk18),
      .rst      (rst),
      .key_n    (key_n),
      .key_db   (key_db),
      .press_ev (press_ev)
   );
   always_comb begin
      dup       = 1'b0;
      range_err = 1'b0;
      for (int i = 0; i < N_DIG; i++) begin
`ifdef GUESS_INPUT_DEC_CHECK_EN
         if (digit(code, i) > MAX_DEC) range_err = 1'b1;
`endif
         for (int j = i + 1; j < N_DIG; j++)
            if (digit(code, i) == digit(code, j)) dup = 1'b1;
      end
      why = range_err ? REJ_RANGE : dup ? REJ_DUP : REJ_NONE;
   end
   always_ff @(posedge clk18 or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= nxt;
   always_comb begin
      nxt  = state;
      cap  = 1'b0;
      xfer = 1'b0;
      case (state)
         IDLE:    if (press_ev) begin
                     nxt = CHECK;
                     cap = 1'b1;
                  end
         CHECK:   nxt = (why == REJ_NONE) ? HOLD : RELEASE;
         HOLD:    if (code_ready) begin
                     xfer = 1'b1;
                     nxt  = key_db ? RELEASE : IDLE;
                  end
         RELEASE: nxt = key_db ? RELEASE : IDLE;
         default: nxt = IDLE;
      endcase
      if (clr) begin
         nxt  = key_db ? RELEASE : IDLE;
         cap  = 1'b0;
         xfer = 1'b0;
      end
      rej = (state == CHECK) && (why != REJ_NONE) && !clr;
   end
   assign code_valid = (state == HOLD);
   always_ff @(posedge clk18 or negedge rst)
      if (!rst) begin
         code       <= '0;
         reject     <= 1'b0;
         reject_why <= REJ_NONE;
         attempts   <= '0;
      end else begin
         reject <= rej;
         if (cap) begin
            code       <= sw;
            reject_why <= REJ_NONE;
         end
         if (rej) reject_why <= why;
         if (clr) attempts <= '0;
         else if (xfer && attempts != '1) attempts <= attempts + 1'b1;
      end
endmodule
